// File: rtl/traffic_phase_scheduler_pkg.sv
// Shared definitions for the intersection scheduler: lamp codes and phase encodings.
package traffic_phase_scheduler_pkg;

    typedef enum logic [1:0] {
        LT_RED    = 2'b00,
        LT_YELLOW = 2'b01,
        LT_GREEN  = 2'b10
    } light_e;

    // Encodings are visible on state_out and must stay fixed.
    typedef enum logic [2:0] {
        ST_MG  = 3'd0,
        ST_MY  = 3'd1,
        ST_AR1 = 3'd2,
        ST_SG  = 3'd3,
        ST_SY  = 3'd4,
        ST_PW  = 3'd5,
        ST_AR2 = 3'd6
    } phase_e;

endpackage

// File: rtl/traffic_phase_scheduler_phase_timer.sv
// Phase cycle counter: clears on request, counts when enabled, optionally holds at a limit.
module phase_timer #(
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic             sat_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && !(sat_i && (count_q >= limit_i))) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-road intersection sequencer with latched pedestrian requests; Moore outputs.
module traffic_phase_scheduler
    import traffic_phase_scheduler_pkg::*;
#(
    parameter int unsigned CNT_W     = 5,
    parameter int unsigned MIN_GREEN = 8,
    parameter int unsigned YELLOW_T  = 3,
    parameter int unsigned ALLRED_T  = 2,
    parameter int unsigned SIDE_MIN  = 4,
    parameter int unsigned SIDE_MAX  = 10,
    parameter int unsigned WALK_T    = 6
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       side_req,
    input  logic       ped_req,
    output logic [1:0] main_light,
    output logic [1:0] side_light,
    output logic       walk,
    output logic       ped_ack,
    output logic [2:0] state_out
);

    localparam logic [CNT_W-1:0] MG_LAST   = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] SMIN_LAST = CNT_W'(SIDE_MIN - 1);
    localparam logic [CNT_W-1:0] SMAX_LAST = CNT_W'(SIDE_MAX - 1);
    localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(WALK_T - 1);

    phase_e           state_q;
    phase_e           state_d;
    logic             ped_pend_q;
    logic             ped_pend_d;
    logic             serve_ped;
    logic [CNT_W-1:0] timer;

    phase_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk_i   (clock),
        .rst_i   (reset),
        .clear_i (state_d != state_q),
        .en_i    (1'b1),
        .sat_i   (state_q == ST_MG),
        .limit_i (MG_LAST),
        .count_o (timer)
    );

    always_comb begin
        state_d   = state_q;
        serve_ped = 1'b0;
        unique case (state_q)
            ST_MG:  if ((timer >= MG_LAST) && (side_req || ped_pend_q)) state_d = ST_MY;
            ST_MY:  if (timer == YEL_LAST) state_d = ST_AR1;
            ST_AR1: begin
                if (timer == AR_LAST) begin
                    if (ped_pend_q) begin
                        state_d   = ST_PW;
                        serve_ped = 1'b1;
                    end else begin
                        state_d = ST_SG;
                    end
                end
            end
            ST_SG: begin
                if ((timer == SMAX_LAST) || (!side_req && (timer >= SMIN_LAST))) state_d = ST_SY;
            end
            ST_SY:  if (timer == YEL_LAST) state_d = ST_AR2;
            ST_PW:  if (timer == WALK_LAST) state_d = ST_AR2;
            ST_AR2: if (timer == AR_LAST) state_d = ST_MG;
            default: state_d = ST_MG;
        endcase
        // A press arriving on the serving edge stays pending for the next cycle.
        ped_pend_d = ped_req || (ped_pend_q && !serve_ped);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_MG;
            ped_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ped_pend_q <= ped_pend_d;
        end
    end

    always_comb begin
        main_light = LT_RED;
        side_light = LT_RED;
        walk       = 1'b0;
        ped_ack    = 1'b0;
        case (state_q)
            ST_MG: main_light = LT_GREEN;
            ST_MY: main_light = LT_YELLOW;
            ST_SG: side_light = LT_GREEN;
            ST_SY: side_light = LT_YELLOW;
            ST_PW: begin
                walk    = 1'b1;
                ped_ack = (timer == '0);
            end
            default: ;
        endcase
    end

    assign state_out = state_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: directed timelines plus randomized run against a phase model.
module tb_traffic_phase_scheduler;
    import traffic_phase_scheduler_pkg::*;

    localparam int MIN_GREEN = 8;
    localparam int YELLOW_T  = 3;
    localparam int ALLRED_T  = 2;
    localparam int SIDE_MIN  = 4;
    localparam int SIDE_MAX  = 10;
    localparam int WALK_T    = 6;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       side_req = 1'b0;
    logic       ped_req = 1'b0;
    logic [1:0] main_light;
    logic [1:0] side_light;
    logic       walk;
    logic       ped_ack;
    logic [2:0] state_out;

    int vectors = 0;
    int miscompares = 0;

    // Reference: current phase, cycles already spent in it (unbounded), pending press.
    phase_e m_phase = ST_MG;
    int     m_elapsed = 0;
    bit     m_pend = 1'b0;

    traffic_phase_scheduler #(
        .CNT_W     (5),
        .MIN_GREEN (MIN_GREEN),
        .YELLOW_T  (YELLOW_T),
        .ALLRED_T  (ALLRED_T),
        .SIDE_MIN  (SIDE_MIN),
        .SIDE_MAX  (SIDE_MAX),
        .WALK_T    (WALK_T)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .side_req   (side_req),
        .ped_req    (ped_req),
        .main_light (main_light),
        .side_light (side_light),
        .walk       (walk),
        .ped_ack    (ped_ack),
        .state_out  (state_out)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        vectors++;
        if (((main_light != 2'b00) && (side_light != 2'b00)) ||
            (walk && ((main_light != 2'b00) || (side_light != 2'b00)))) begin
            miscompares++;
            $display("FAIL safety t=%0t main=%b side=%b walk=%b required no conflicting green/walk",
                     $time, main_light, side_light, walk);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [1:0] exp_main(phase_e p);
        if (p == ST_MG) return 2'b10;
        if (p == ST_MY) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [1:0] exp_side(phase_e p);
        if (p == ST_SG) return 2'b10;
        if (p == ST_SY) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_advance(input bit s, input bit p, input bit r);
        phase_e nxt    = m_phase;
        bit     served = 1'b0;
        int     held   = m_elapsed + 1;
        if (r) begin
            m_phase   = ST_MG;
            m_elapsed = 0;
            m_pend    = 1'b0;
        end else begin
            case (m_phase)
                ST_MG:  if (held >= MIN_GREEN && (s || m_pend)) nxt = ST_MY;
                ST_MY:  if (held == YELLOW_T) nxt = ST_AR1;
                ST_AR1: if (held == ALLRED_T) begin
                    nxt    = m_pend ? ST_PW : ST_SG;
                    served = m_pend;
                end
                ST_SG:  if (held == SIDE_MAX || (!s && held >= SIDE_MIN)) nxt = ST_SY;
                ST_SY:  if (held == YELLOW_T) nxt = ST_AR2;
                ST_PW:  if (held == WALK_T) nxt = ST_AR2;
                default: if (held == ALLRED_T) nxt = ST_MG;
            endcase
            m_pend = p || (m_pend && !served);
            if (nxt != m_phase) begin
                m_phase   = nxt;
                m_elapsed = 0;
            end else begin
                m_elapsed = held;
            end
        end
    endtask

    // One clock period: check outputs against the model, apply inputs, advance.
    task automatic tick(input bit s, input bit p, input bit r);
        logic [8:0] exp_v;
        logic [8:0] got_v;
        exp_v = {exp_main(m_phase), exp_side(m_phase), (m_phase == ST_PW),
                 (m_phase == ST_PW && m_elapsed == 0), 3'(m_phase)};
        got_v = {main_light, side_light, walk, ped_ack, state_out};
        vectors++;
        if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL model t=%0t {main,side,walk,ack,state} got=%b required=%b",
                     $time, got_v, exp_v);
        end
        side_req = s;
        ped_req  = p;
        reset    = r;
        model_advance(s, p, r);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input int n);
        side_req = 1'b0;
        ped_req  = 1'b0;
        reset    = 1'b1;
        repeat (n) @(posedge clock);
        #1;
        reset = 1'b0;
        model_advance(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset;
        do_reset(3);
        vectors++;
        if ({main_light, side_light, walk, ped_ack, state_out} !== 9'b10_00_0_0_000) begin
            miscompares++;
            $display("FAIL reset_values got=%b required=%b",
                     {main_light, side_light, walk, ped_ack, state_out}, 9'b10_00_0_0_000);
        end
    endtask

    task automatic test_idle;
        do_reset(3);
        for (int c = 0; c < 50; c++) begin
            vectors++;
            if ({main_light, side_light, walk, state_out} !== 8'b10_00_0_000) begin
                miscompares++;
                $display("FAIL idle c=%0d got=%b required=%b", c,
                         {main_light, side_light, walk, state_out}, 8'b10_00_0_000);
            end
            tick(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_side_full;
        logic [1:0] em;
        logic [1:0] es;
        do_reset(3);
        for (int c = 0; c <= 28; c++) begin
            em = (c < 8 || c >= 28) ? 2'b10 : (c <= 10) ? 2'b01 : 2'b00;
            es = (c >= 13 && c <= 22) ? 2'b10 : (c >= 23 && c <= 25) ? 2'b01 : 2'b00;
            vectors++;
            if ({main_light, side_light} !== {em, es}) begin
                miscompares++;
                $display("FAIL side_full c=%0d main/side got=%b/%b required=%b/%b",
                         c, main_light, side_light, em, es);
            end
            tick(1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic test_side_min;
        logic [1:0] es;
        do_reset(3);
        for (int c = 0; c <= 17; c++) begin
            es = (c >= 13 && c <= 16) ? 2'b10 : (c == 17) ? 2'b01 : 2'b00;
            vectors++;
            if (side_light !== es) begin
                miscompares++;
                $display("FAIL side_min c=%0d side got=%b required=%b", c, side_light, es);
            end
            tick(c <= 14, 1'b0, 1'b0);
        end
    endtask

    task automatic test_ped_only;
        logic [2:0] es;
        do_reset(3);
        for (int c = 0; c <= 21; c++) begin
            es = (c < 8) ? 3'd0 : (c <= 10) ? 3'd1 : (c <= 12) ? 3'd2 :
                 (c <= 18) ? 3'd5 : (c <= 20) ? 3'd6 : 3'd0;
            vectors++;
            if ({state_out, walk, ped_ack, side_light} !==
                {es, (c >= 13 && c <= 18), (c == 13), 2'b00}) begin
                miscompares++;
                $display("FAIL ped_only c=%0d state/walk/ack/side got=%0d/%b/%b/%b required=%0d/%b/%b/00",
                         c, state_out, walk, ped_ack, side_light, es,
                         (c >= 13 && c <= 18), (c == 13));
            end
            tick(1'b0, c == 3, 1'b0);
        end
    endtask

    task automatic test_ped_priority;
        logic [2:0] es;
        do_reset(3);
        for (int c = 0; c <= 35; c++) begin
            es = (c < 8) ? 3'd0 : (c <= 10) ? 3'd1 : (c <= 12) ? 3'd2 : (c <= 18) ? 3'd5 :
                 (c <= 20) ? 3'd6 : (c <= 28) ? 3'd0 : (c <= 31) ? 3'd1 :
                 (c <= 33) ? 3'd2 : 3'd3;
            vectors++;
            if (state_out !== es) begin
                miscompares++;
                $display("FAIL ped_priority c=%0d state got=%0d required=%0d", c, state_out, es);
            end
            tick(1'b1, c == 0, 1'b0);
        end
    endtask

    task automatic test_reset_mid_phase;
        do_reset(3);
        for (int c = 0; c <= 60; c++) begin
            if (c == 15) begin
                vectors++;
                if (state_out !== 3'd3) begin
                    miscompares++;
                    $display("FAIL midreset_setup c=%0d state got=%0d required=3", c, state_out);
                end
            end
            if (c == 17) begin
                vectors++;
                if ({main_light, side_light, walk, ped_ack, state_out} !== 9'b10_00_0_0_000) begin
                    miscompares++;
                    $display("FAIL midreset_values got=%b required=%b",
                             {main_light, side_light, walk, ped_ack, state_out}, 9'b10_00_0_0_000);
                end
            end
            if (c >= 17) begin
                vectors++;
                if (walk !== 1'b0 || state_out === 3'd5) begin
                    miscompares++;
                    $display("FAIL midreset_no_walk c=%0d walk got=%b state=%0d required walk=0 state!=5",
                             c, walk, state_out);
                end
            end
            tick(c <= 16, c == 14, c == 16);
        end
    endtask

    task automatic test_random;
        bit s = 1'b0;
        do_reset(2);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) s = ~s;
            tick(s, $urandom_range(19) == 0, $urandom_range(499) == 0);
        end
    endtask

    task automatic test_back_to_back;
        do_reset(1);
        for (int i = 0; i < 200; i++) begin
            tick(1'b1, (i % 3) == 0, 1'b0);
        end
    endtask

    initial begin
        @(posedge clock);
        #1;
        test_reset;
        test_idle;
        test_side_full;
        test_side_min;
        test_ped_only;
        test_ped_priority;
        test_reset_mid_phase;
        test_back_to_back;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
